// File: rtl/wb_stage.sv
// Registered write-back select with load align/extend; rf write one cycle after acceptance.
// Backpressure: in_ready drops only while a selected accumulator result is pending (busy).
module wb_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_we,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [2:0]         in_sel,
    input  logic [1:0]         in_ld_size,
    input  logic               in_ld_unsigned,
    input  logic [1:0]         in_addr_lo,
    input  logic [XLEN-1:0]    alu_data,
    input  logic [XLEN-1:0]    mem_data,
    input  logic [XLEN-1:0]    imm_data,
    input  logic [XLEN-1:0]    acc1_data,
    input  logic [XLEN-1:0]    acc2_data,
    input  logic               acc1_valid,
    input  logic               acc2_valid,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               wb_err,
    output logic               busy
);

    typedef enum logic {IDLE, WAIT_ACC} state_t;

    localparam logic [2:0] SEL_ALU  = 3'd0;
    localparam logic [2:0] SEL_MEM  = 3'd1;
    localparam logic [2:0] SEL_IMM  = 3'd2;
    localparam logic [2:0] SEL_ACC1 = 3'd3;
    localparam logic [2:0] SEL_ACC2 = 3'd4;

    state_t state, state_nxt;

    logic               lat_we;
    logic               lat_acc2;
    logic [RADDR_W-1:0] lat_rd;
    logic               lat_load;

    logic               wr_load;
    logic               wr_we;
    logic               wr_err;
    logic [RADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]    wr_data;

    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_word;
    logic [XLEN-1:0]    ld_ext;
    logic               ld_misaligned;
    logic               pend_valid;

    // Lanes are always taken from the low 32 bits, also on a 64-bit datapath.
    always_comb begin
        ld_byte = 8'h00;
        ld_half = 16'h0000;
        ld_word = mem_data[31:0];
        case (in_addr_lo)
            2'd0:    ld_byte = mem_data[7:0];
            2'd1:    ld_byte = mem_data[15:8];
            2'd2:    ld_byte = mem_data[23:16];
            default: ld_byte = mem_data[31:24];
        endcase
        ld_half = in_addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
        case (in_ld_size)
            2'b00:   ld_ext = in_ld_unsigned ? {{(XLEN-8){1'b0}}, ld_byte}
                                             : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = in_ld_unsigned ? {{(XLEN-16){1'b0}}, ld_half}
                                             : {{(XLEN-16){ld_half[15]}}, ld_half};
            default: ld_ext = in_ld_unsigned ? {{(XLEN-32){1'b0}}, ld_word}
                                             : {{(XLEN-32){ld_word[31]}}, ld_word};
        endcase
        case (in_ld_size)
            2'b00:   ld_misaligned = 1'b0;
            2'b01:   ld_misaligned = in_addr_lo[0];
            default: ld_misaligned = (in_addr_lo != 2'd0);
        endcase
    end

    assign in_ready   = rst_n & (state == IDLE);
    assign busy       = (state == WAIT_ACC);
    assign pend_valid = lat_acc2 ? acc2_valid : acc1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lat_load  = 1'b0;
        wr_load   = 1'b0;
        wr_we     = 1'b0;
        wr_err    = 1'b0;
        wr_addr   = in_rd;
        wr_data   = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    wr_load = 1'b1;
                    wr_we   = in_we && (in_rd != '0);
                    case (in_sel)
                        SEL_ALU: wr_data = alu_data;
                        SEL_IMM: wr_data = imm_data;
                        SEL_MEM: begin
                            wr_data = ld_ext;
                            if (ld_misaligned) begin
                                wr_we  = 1'b0;
                                wr_err = 1'b1;
                            end
                        end
                        SEL_ACC1: begin
                            if (acc1_valid) begin
                                wr_data = acc1_data;
                            end else begin
                                wr_load   = 1'b0;
                                wr_we     = 1'b0;
                                lat_load  = 1'b1;
                                state_nxt = WAIT_ACC;
                            end
                        end
                        SEL_ACC2: begin
                            if (acc2_valid) begin
                                wr_data = acc2_data;
                            end else begin
                                wr_load   = 1'b0;
                                wr_we     = 1'b0;
                                lat_load  = 1'b1;
                                state_nxt = WAIT_ACC;
                            end
                        end
                        default: begin
                            wr_we  = 1'b0;
                            wr_err = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_ACC: begin
                if (pend_valid) begin
                    wr_load   = 1'b1;
                    wr_we     = lat_we && (lat_rd != '0);
                    wr_addr   = lat_rd;
                    wr_data   = lat_acc2 ? acc2_data : acc1_data;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            wb_err   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            lat_we   <= 1'b0;
            lat_acc2 <= 1'b0;
            lat_rd   <= '0;
        end else begin
            rf_we  <= wr_we;
            wb_err <= wr_err;
            if (wr_load) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
            end
            if (lat_load) begin
                lat_we   <= in_we;
                lat_rd   <= in_rd;
                lat_acc2 <= (in_sel == SEL_ACC2);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_we;
    logic [4:0]  in_rd;
    logic [2:0]  in_sel;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [1:0]  in_addr_lo;
    logic [31:0] alu_data, mem_data, imm_data, acc1_data, acc2_data;
    logic        acc1_valid, acc2_valid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_rd(in_rd),
        .in_sel(in_sel), .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
        .in_addr_lo(in_addr_lo),
        .alu_data(alu_data), .mem_data(mem_data), .imm_data(imm_data),
        .acc1_data(acc1_data), .acc2_data(acc2_data),
        .acc1_valid(acc1_valid), .acc2_valid(acc2_valid),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_err(wb_err), .busy(busy)
    );

    typedef struct {
        logic [2:0]  sel;
        logic        we;
        logic [4:0]  rd;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lo;
        logic [31:0] alu, mem, imm, acc1, acc2;
        logic        a1v, a2v;
        logic        exp_we;
        logic        exp_err;
        logic [31:0] exp_data;
        logic        chk_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] sel, input logic we, input logic [4:0] rd,
                                input logic [1:0] size, input logic uns, input logic [1:0] lo,
                                input logic [31:0] src, input logic a1v, input logic a2v,
                                input logic exp_we, input logic exp_err,
                                input logic [31:0] exp_data, input logic chk_data);
        vec_t v;
        v.sel = sel; v.we = we; v.rd = rd; v.size = size; v.uns = uns; v.lo = lo;
        v.alu = 32'h0;  v.mem = 32'h0; v.imm = 32'h0;
        v.acc1 = 32'hDEAD0001; v.acc2 = 32'hDEAD0002;
        case (sel)
            3'd0: v.alu = src;
            3'd1: v.mem = src;
            3'd2: v.imm = src;
            3'd3: v.acc1 = src;
            3'd4: v.acc2 = src;
            default: v.alu = src;
        endcase
        v.a1v = a1v; v.a2v = a2v;
        v.exp_we = exp_we; v.exp_err = exp_err; v.exp_data = exp_data; v.chk_data = chk_data;
        return v;
    endfunction

    // Reference: lane pick and extension done with integer shifts and range arithmetic.
    task automatic model(input vec_t v, output logic we, output logic err,
                         output logic [31:0] data, output logic chkd);
        longint val;
        int     bits;
        int     shift;
        logic   misal, illegal;
        illegal = (v.sel > 3'd4);
        misal   = (v.sel == 3'd1) &&
                  ((v.size == 2'd1 && (v.lo % 2) != 0) || (v.size >= 2'd2 && v.lo != 2'd0));
        val = 0;
        case (v.sel)
            3'd0: val = longint'(v.alu);
            3'd2: val = longint'(v.imm);
            3'd3: val = longint'(v.acc1);
            3'd4: val = longint'(v.acc2);
            3'd1: begin
                bits  = (v.size == 2'd0) ? 8 : (v.size == 2'd1) ? 16 : 32;
                shift = (v.size == 2'd0) ? 8 * int'(v.lo) : (v.size == 2'd1) ? 16 * (int'(v.lo) / 2) : 0;
                val   = (longint'(v.mem) >> shift) % (longint'(1) << bits);
                if (!v.uns && val >= (longint'(1) << (bits - 1))) val = val - (longint'(1) << bits);
            end
            default: val = 0;
        endcase
        we   = v.we && (v.rd != 0) && !misal && !illegal;
        err  = misal || illegal;
        data = val[31:0];
        chkd = !misal;
    endtask

    task automatic drive(input vec_t v, input logic valid);
        in_valid = valid; in_sel = v.sel; in_we = v.we; in_rd = v.rd;
        in_ld_size = v.size; in_ld_unsigned = v.uns; in_addr_lo = v.lo;
        alu_data = v.alu; mem_data = v.mem; imm_data = v.imm;
        acc1_data = v.acc1; acc2_data = v.acc2; acc1_valid = v.a1v; acc2_valid = v.a2v;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_sel = 0; in_we = 0; in_rd = 0; in_ld_size = 0; in_ld_unsigned = 0;
        in_addr_lo = 0; alu_data = 0; mem_data = 0; imm_data = 0; acc1_data = 0; acc2_data = 0;
        acc1_valid = 0; acc2_valid = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_waddr"}, rf_waddr, 0);
        chk({tag, "_wdata"}, rf_wdata, 0);
        chk({tag, "_err"}, wb_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, in_ready, 0);
    endtask

    vec_t tbl[15];
    vec_t rv;
    logic m_we, m_err, m_chk;
    logic [31:0] m_data;

    initial begin
        tbl[0]  = mk(3'd0, 1, 5'd5, 2'd0, 0, 2'd0, 32'h12345678, 0, 0, 1, 0, 32'h12345678, 1);
        tbl[1]  = mk(3'd1, 1, 5'd6, 2'd0, 0, 2'd2, 32'h00800000, 0, 0, 1, 0, 32'hFFFFFF80, 1);
        tbl[2]  = mk(3'd1, 1, 5'd6, 2'd0, 1, 2'd2, 32'h00800000, 0, 0, 1, 0, 32'h00000080, 1);
        tbl[3]  = mk(3'd1, 1, 5'd7, 2'd1, 0, 2'd1, 32'h11223344, 0, 0, 0, 1, 32'h0, 0);
        tbl[4]  = mk(3'd1, 1, 5'd8, 2'd2, 0, 2'd0, 32'hCAFEBABE, 0, 0, 1, 0, 32'hCAFEBABE, 1);
        tbl[5]  = mk(3'd2, 1, 5'd0, 2'd0, 0, 2'd0, 32'h0000FFFF, 0, 0, 0, 0, 32'h0000FFFF, 1);
        tbl[6]  = mk(3'd7, 1, 5'd0, 2'd0, 0, 2'd0, 32'h55555555, 0, 0, 0, 1, 32'h0, 1);
        tbl[7]  = mk(3'd3, 1, 5'd9, 2'd0, 0, 2'd0, 32'h0BADF00D, 1, 0, 1, 0, 32'h0BADF00D, 1);
        tbl[8]  = mk(3'd4, 1, 5'd10, 2'd0, 0, 2'd0, 32'h13572468, 1, 1, 1, 0, 32'h13572468, 1);
        tbl[9]  = mk(3'd1, 1, 5'd11, 2'd1, 0, 2'd2, 32'h80011234, 0, 0, 1, 0, 32'hFFFF8001, 1);
        tbl[10] = mk(3'd1, 1, 5'd12, 2'd1, 1, 2'd0, 32'h8001F234, 0, 0, 1, 0, 32'h0000F234, 1);
        tbl[11] = mk(3'd0, 0, 5'd4, 2'd0, 0, 2'd0, 32'h0F0F0F0F, 0, 0, 0, 0, 32'h0F0F0F0F, 1);
        tbl[12] = mk(3'd1, 1, 5'd13, 2'd2, 0, 2'd2, 32'h12345678, 0, 0, 0, 1, 32'h0, 0);
        tbl[13] = mk(3'd1, 1, 5'd14, 2'd0, 0, 2'd3, 32'h7F000000, 0, 0, 1, 0, 32'h0000007F, 1);
        tbl[14] = mk(3'd1, 1, 5'd15, 2'd3, 0, 2'd0, 32'h89ABCDEF, 0, 0, 1, 0, 32'h89ABCDEF, 1);

        idle_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        #1 chk("ready_after_release", in_ready, 1);

        // Table: accept one vector, check the write, then check the strobe lasts one cycle.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk) drive(tbl[i], 1'b1);
            @(posedge clk); #1;
            idle_inputs();
            chk($sformatf("tbl%0d_we", i), rf_we, tbl[i].exp_we);
            chk($sformatf("tbl%0d_err", i), wb_err, tbl[i].exp_err);
            chk($sformatf("tbl%0d_waddr", i), rf_waddr, tbl[i].rd);
            if (tbl[i].chk_data) chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].exp_data);
            chk($sformatf("tbl%0d_busy", i), busy, 0);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_we_drop", i), rf_we, 0);
            chk($sformatf("tbl%0d_err_drop", i), wb_err, 0);
        end

        // ACC1 stall with acc2 pulses, then a queued ALU op accepted right after resolution.
        @(negedge clk) drive(mk(3'd3, 1, 5'd7, 2'd0, 0, 2'd0, 32'h0, 0, 0, 0, 0, 0, 0), 1'b1);
        @(posedge clk); #1;
        drive(mk(3'd0, 1, 5'd9, 2'd0, 0, 2'd0, 32'h00001111, 0, 0, 0, 0, 0, 0), 1'b1);
        for (int c = 0; c < 3; c++) begin
            acc2_valid = c[0] ? 1'b0 : 1'b1;
            acc2_data  = 32'h77770000 + c;
            chk($sformatf("stall%0d_busy", c), busy, 1);
            chk($sformatf("stall%0d_ready", c), in_ready, 0);
            chk($sformatf("stall%0d_we", c), rf_we, 0);
            @(posedge clk); #1;
        end
        chk("stall_last_we", rf_we, 0);
        chk("stall_last_busy", busy, 1);
        acc2_valid = 0;
        acc1_valid = 1; acc1_data = 32'hA5A5A5A5;
        @(posedge clk); #1;
        acc1_valid = 0;
        chk("acc_res_we", rf_we, 1);
        chk("acc_res_waddr", rf_waddr, 7);
        chk("acc_res_wdata", rf_wdata, 32'hA5A5A5A5);
        chk("acc_res_busy", busy, 0);
        chk("acc_res_ready", in_ready, 1);
        @(posedge clk); #1;
        idle_inputs();
        chk("post_acc_we", rf_we, 1);
        chk("post_acc_waddr", rf_waddr, 9);
        chk("post_acc_wdata", rf_wdata, 32'h00001111);
        @(posedge clk); #1;
        chk("post_acc_drop", rf_we, 0);

        // Reset during WAIT_ACC drops the pending write.
        @(negedge clk) drive(mk(3'd4, 1, 5'd3, 2'd0, 0, 2'd0, 32'h0, 0, 0, 0, 0, 0, 0), 1'b1);
        @(posedge clk); #1;
        idle_inputs();
        chk("rst_wait_busy", busy, 1);
        @(negedge clk) rst_n = 0;
        acc2_valid = 1; acc2_data = 32'hBEEFBEEF;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        #1 chk("rst_mid_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("rst_mid_no_we", rf_we, 0);
        chk("rst_mid_no_busy", busy, 0);
        idle_inputs();

        // Randomized back-to-back traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            rv.sel  = 3'($urandom_range(0, 7));
            rv.we   = 1'($urandom_range(0, 3) != 0);
            rv.rd   = 5'($urandom);
            rv.size = 2'($urandom);
            rv.uns  = 1'($urandom);
            rv.lo   = 2'($urandom);
            rv.alu  = $urandom; rv.mem = $urandom; rv.imm = $urandom;
            rv.acc1 = $urandom; rv.acc2 = $urandom;
            rv.a1v  = 1'($urandom) || (rv.sel == 3'd3);
            rv.a2v  = 1'($urandom) || (rv.sel == 3'd4);
            model(rv, m_we, m_err, m_data, m_chk);
            if (m_err) begin
                rv.we = 1'b1;
                model(rv, m_we, m_err, m_data, m_chk);
            end
            drive(rv, 1'($urandom_range(0, 3) != 0));
            @(posedge clk); #1;
            if (in_valid) begin
                chk($sformatf("rnd%0d_we", i), rf_we, m_we);
                chk($sformatf("rnd%0d_err", i), wb_err, m_err);
                chk($sformatf("rnd%0d_waddr", i), rf_waddr, rv.rd);
                if (m_chk) chk($sformatf("rnd%0d_wdata", i), rf_wdata, m_data);
            end else begin
                chk($sformatf("rnd%0d_idle_we", i), rf_we, 0);
                chk($sformatf("rnd%0d_idle_err", i), wb_err, 0);
            end
            chk($sformatf("rnd%0d_ready", i), in_ready, 1);
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered, parametrised write-back stage for the core. It replaces the purely combinational write-back selection with a pipelined block. The block selects among ALU, load, immediate and two accumulator sources, and aligns and sign/zero-extends load data. It stalls on accumulator results that are not yet available, and drives the register-file write port one cycle after acceptance.

## Interface
Parameters:
- XLEN, 32, datapath width; must be 32 or 64, load extension assumes byte lanes
- RADDR_W, 5, register-file address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present at write-back input
- in_ready  out  1  stage can accept; transfer on in_valid & in_ready at rising edge
- in_we  in  1  instruction writes a register
- in_rd  in  RADDR_W  destination register
- in_sel  in  3  source: 000 ALU, 001 MEM, 010 IMM, 011 ACC1, 100 ACC2, others illegal
- in_ld_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- in_ld_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
- in_addr_lo  in  2  load address bits [1:0]
- alu_data, mem_data, imm_data  in  XLEN  source data, sampled at acceptance
- acc1_data, acc2_data  in  XLEN  accumulator results
- acc1_valid, acc2_valid  in  1  accumulator result valid this cycle
- rf_we  out  1  register-file write strobe, one cycle
- rf_waddr  out  RADDR_W  write address
- rf_wdata  out  XLEN  write data
- wb_err  out  1  one-cycle pulse: illegal in_sel or misaligned load
- busy  out  1  high in WAIT_ACC

## Operation
- FSM states: IDLE, WAIT_ACC.
- IDLE: in_ready=1. On acceptance:
  - Non-accumulator source: compute data and register rf_we/rf_waddr/rf_wdata. Stay in IDLE.
  - ACC source with its valid high in the same cycle: same as the non-accumulator case.
  - ACC source with its valid low: latch in_rd, in_we and sel, then go to WAIT_ACC.
- WAIT_ACC: in_ready=0, busy=1. Only the latched accumulator's valid is monitored. When it is high, register its data as the write, then go to IDLE.
- MEM path:
  - Byte: lane = mem_data[8*addr_lo +: 8].
  - Half: lane = mem_data[16*addr_lo[1] +: 16].
  - Word: mem_data[31:0].
  - The selected lane is extended to XLEN per in_ld_unsigned. Word loads on XLEN=64 are always extended per in_ld_unsigned.
- Misaligned load (half with addr_lo[0]=1, word with addr_lo≠0): rf_we=0 and wb_err=1 for one cycle.
- Illegal in_sel: rf_we=0, wb_err=1, rf_wdata=0.
- in_rd=0: rf_we forced 0; rf_waddr and rf_wdata still update; no error.
- in_we=0: rf_we=0; no error.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, wb_err=0, busy=0, state=IDLE.
  - in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Latency: acceptance at edge N gives rf_we high during cycle N..N+1, exactly one cycle. Back-to-back acceptances give back-to-back writes.
- Accumulator stall: if acc valid is first seen high at edge M while in WAIT_ACC:
  - The write is visible in the cycle after M.
  - in_ready rises in the cycle after M.
  - A new acceptance is possible at edge M+1.
- Acc valid rising in the same cycle as acceptance bypasses WAIT_ACC entirely.
- The non-selected accumulator's valid is ignored in every state.
- rf_we, wb_err and busy are registered; no combinational path from inputs to rf_* outputs. in_ready is a decode of state only.
- Reset asserted mid-WAIT_ACC: the pending write is dropped and no rf_we is issued after release.
- Source data is captured only at acceptance, except ACC data, which is captured at the resolving edge.

## Test plan
- Reset release, then ALU sel, rd=5, alu_data=0x12345678 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678; following cycle rf_we=0.
- MEM byte signed, addr_lo=2, mem_data=0x00800000 → rf_wdata=0xFFFFFF80. Same with unsigned → 0x00000080.
- MEM half with addr_lo=1 → rf_we=0, wb_err=1 for one cycle. Word with addr_lo=0 and mem_data=0xCAFEBABE → written unchanged.
- ACC1 sel with acc1_valid=0 for 3 cycles, then acc1_valid=1, acc1_data=0xA5A5A5A5 →
  - busy=1 and in_ready=0 for 3 cycles.
  - One write of 0xA5A5A5A5.
  - acc2_valid pulses during the wait cause no write.
- rd=0 with IMM 0xFFFF, then sel=111 → rf_we=0 for both; wb_err only on the second.
- Reset asserted during WAIT_ACC → all outputs 0, no write after release, in_ready=1 the first cycle after release.
